// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_if
// Purpose  : Core-side request/response and data-memory port bundle of the
//            load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
  logic        core_valid;
  logic        core_we;
  logic [2:0]  core_funct3;
  logic [63:0] core_addr;
  logic [63:0] core_wdata;
  logic        core_stall;
  logic        core_done;
  logic        core_fault;
  logic [63:0] core_rdata;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wmask;
  logic        dmem_resp_valid;
  logic [63:0] dmem_resp_data;

  // Environment view: the pipeline plus the data memory.
  modport master (
    output core_valid, core_we, core_funct3, core_addr, core_wdata,
    output dmem_req_ready, dmem_resp_valid, dmem_resp_data,
    input  core_stall, core_done, core_fault, core_rdata,
    input  dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wmask
  );

  // Load/store unit view.
  modport slave (
    input  core_valid, core_we, core_funct3, core_addr, core_wdata,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp_data,
    output core_stall, core_done, core_fault, core_rdata,
    output dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wmask
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : RV64 memory-access stage: one load/store per request, lane
//            alignment of store data/mask and load extraction/extension.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit (
  input wire clk,
  input wire rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] c_F3_B  = 3'b000;
  localparam logic [2:0] c_F3_H  = 3'b001;
  localparam logic [2:0] c_F3_W  = 3'b010;
  localparam logic [2:0] c_F3_D  = 3'b011;
  localparam logic [2:0] c_F3_BU = 3'b100;
  localparam logic [2:0] c_F3_HU = 3'b101;
  localparam logic [2:0] c_F3_WU = 3'b110;

  state_t      r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [7:0]  r_wmask;
  logic        r_req_valid;
  logic        r_done;
  logic        r_fault;
  logic [63:0] r_rdata;

  logic        w_misaligned;
  logic        w_illegal;
  logic [7:0]  w_mask_base;
  logic [5:0]  w_wr_shamt;
  logic [63:0] w_lane_data;
  logic [63:0] w_load_data;

  // Width decode of the incoming request: alignment check and unshifted mask.
  always_comb begin
    w_misaligned = 1'b0;
    w_illegal    = 1'b0;
    w_mask_base  = 8'h00;
    case (bus.core_funct3)
      c_F3_B, c_F3_BU: begin
        w_mask_base = 8'h01;
      end
      c_F3_H, c_F3_HU: begin
        w_mask_base  = 8'h03;
        w_misaligned = bus.core_addr[0];
      end
      c_F3_W, c_F3_WU: begin
        w_mask_base  = 8'h0F;
        w_misaligned = (bus.core_addr[1:0] != 2'b00);
      end
      c_F3_D: begin
        w_mask_base  = 8'hFF;
        w_misaligned = (bus.core_addr[2:0] != 3'b000);
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  assign w_wr_shamt  = {bus.core_addr[2:0], 3'b000};
  assign w_lane_data = bus.dmem_resp_data >> {r_addr[2:0], 3'b000};

  // Load extraction from the addressed byte lane, sign or zero extended.
  always_comb begin
    w_load_data = 64'd0;
    case (r_funct3)
      c_F3_B:  w_load_data = {{56{w_lane_data[7]}},  w_lane_data[7:0]};
      c_F3_H:  w_load_data = {{48{w_lane_data[15]}}, w_lane_data[15:0]};
      c_F3_W:  w_load_data = {{32{w_lane_data[31]}}, w_lane_data[31:0]};
      c_F3_D:  w_load_data = w_lane_data;
      c_F3_BU: w_load_data = {56'd0, w_lane_data[7:0]};
      c_F3_HU: w_load_data = {48'd0, w_lane_data[15:0]};
      c_F3_WU: w_load_data = {32'd0, w_lane_data[31:0]};
      default: w_load_data = 64'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= 64'd0;
      r_wdata     <= 64'd0;
      r_wmask     <= 8'h00;
      r_req_valid <= 1'b0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_rdata     <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.core_valid) begin
            r_we     <= bus.core_we;
            r_funct3 <= bus.core_funct3;
            r_addr   <= bus.core_addr;
            r_wdata  <= bus.core_wdata << w_wr_shamt;
            r_wmask  <= w_mask_base << bus.core_addr[2:0];
            // Faulting accesses never reach memory.
            if (w_misaligned || w_illegal) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_fault <= 1'b1;
              r_rdata <= 64'd0;
            end else begin
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (bus.dmem_req_ready) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.dmem_resp_valid) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_fault <= 1'b0;
            r_rdata <= r_we ? 64'd0 : w_load_data;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_fault <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.core_stall     = bus.core_valid & (r_state != S_DONE);
  assign bus.core_done      = r_done;
  assign bus.core_fault     = r_fault;
  assign bus.core_rdata     = r_rdata;
  assign bus.dmem_req_valid = r_req_valid;
  assign bus.dmem_we        = r_we;
  assign bus.dmem_addr      = {r_addr[63:3], 3'b000};
  assign bus.dmem_wdata     = r_wdata;
  assign bus.dmem_wmask     = r_wmask;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed scoreboard bench for load_store_unit with a simple
//            data-memory responder (programmable ready stall / response delay).
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  typedef struct {
    logic [63:0] rdata;
    logic        fault;
    int          lat;
    int          acc;
    int          t0;
  } exp_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accepts = 0;
  int   mem_stall = 0;
  int   resp_delay = 0;
  int   pend = 0;
  logic [63:0] mem_rdata = 64'd0;
  bit   done_flag = 1'b0;
  exp_t sb_q[$];
  req_t req_q[$];

  load_store_unit_if bus();

  load_store_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    tests++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Memory request side: stall-then-accept, and request-field checking.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.dmem_req_valid) begin
        if (req_q.size() == 0) begin
          flag_fail("req_unexpected");
        end else begin
          chk("req_we",    {63'd0, bus.dmem_we}, {63'd0, req_q[0].we});
          chk("req_addr",  bus.dmem_addr,  req_q[0].addr);
          chk("req_wdata", bus.dmem_wdata, req_q[0].wdata);
          chk("req_mask",  {56'd0, bus.dmem_wmask}, {56'd0, req_q[0].mask});
        end
        if (mem_stall > 0) begin
          mem_stall--;
          bus.dmem_req_ready = 1'b0;
        end else begin
          bus.dmem_req_ready = 1'b1;
          accepts++;
          pend = resp_delay + 1;
          if (req_q.size() > 0) void'(req_q.pop_front());
        end
      end else begin
        bus.dmem_req_ready = 1'b0;
      end
    end
  end

  // Memory response side.
  always @(posedge clk) begin
    #1;
    bus.dmem_resp_valid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        bus.dmem_resp_valid = 1'b1;
        bus.dmem_resp_data  = mem_rdata;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.core_valid && !bus.core_done) chk("stall_busy", {63'd0, bus.core_stall}, 64'd1);
      if (bus.core_done) begin
        chk("stall_at_done", {63'd0, bus.core_stall}, 64'd0);
        done_flag = 1'b1;
        if (sb_q.size() == 0) begin
          flag_fail("unexpected_done");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("rdata",   bus.core_rdata, e.rdata);
          chk("fault",   {63'd0, bus.core_fault}, {63'd0, e.fault});
          chk("latency", 64'(cyc - e.t0), 64'(e.lat));
          chk("accepts", 64'(accepts), 64'(e.acc));
        end
      end
    end
  end

  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] memdata, input int stall,
                         input logic exp_fault, input logic [63:0] exp_rdata,
                         input logic [7:0] exp_mask, input logic [63:0] exp_wdata);
    exp_t e;
    req_t r;
    bit   got;
    mem_rdata = memdata;
    mem_stall = stall;
    if (!exp_fault) begin
      r.we    = we;
      r.addr  = {addr[63:3], 3'b000};
      r.wdata = exp_wdata;
      r.mask  = exp_mask;
      req_q.push_back(r);
    end
    e.rdata = exp_rdata;
    e.fault = exp_fault;
    e.lat   = exp_fault ? 1 : 3 + stall;
    e.acc   = accepts + (exp_fault ? 0 : 1);
    e.t0    = cyc;
    sb_q.push_back(e);
    done_flag       = 1'b0;
    bus.core_valid  = 1'b1;
    bus.core_we     = we;
    bus.core_funct3 = f3;
    bus.core_addr   = addr;
    bus.core_wdata  = wdata;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done_flag) begin
        got = 1'b1;
        break;
      end
    end
    bus.core_valid = 1'b0;
    if (!got) begin
      flag_fail("txn_timeout");
      sb_q.delete();
      req_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int a0;
    bus.core_valid      = 1'b0;
    bus.core_we         = 1'b0;
    bus.core_funct3     = 3'b000;
    bus.core_addr       = 64'd0;
    bus.core_wdata      = 64'd0;
    bus.dmem_req_ready  = 1'b0;
    bus.dmem_resp_valid = 1'b0;
    bus.dmem_resp_data  = 64'd0;

    @(negedge clk);
    chk("rst_done",      {63'd0, bus.core_done},      64'd0);
    chk("rst_fault",     {63'd0, bus.core_fault},     64'd0);
    chk("rst_req_valid", {63'd0, bus.dmem_req_valid}, 64'd0);
    chk("rst_we",        {63'd0, bus.dmem_we},        64'd0);
    chk("rst_addr",      bus.dmem_addr,               64'd0);
    chk("rst_wdata",     bus.dmem_wdata,              64'd0);
    chk("rst_mask",      {56'd0, bus.dmem_wmask},     64'd0);
    chk("rst_rdata",     bus.core_rdata,              64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    //       we    f3      addr           wdata                 memdata                stall flt  exp_rdata              mask   exp_wdata
    run_txn(1'b0, 3'b000, 64'h1003, 64'd0,                64'h0000_0000_8000_0000, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 8'h08, 64'd0);
    run_txn(1'b0, 3'b101, 64'h2006, 64'd0,                64'hBEEF_0000_0000_0000, 0, 1'b0, 64'h0000_0000_0000_BEEF, 8'hC0, 64'd0);
    run_txn(1'b1, 3'b010, 64'h3004, 64'h1234_5678,        64'h0000_0000_DEAD_BEEF, 0, 1'b0, 64'd0,                   8'hF0, 64'h1234_5678_0000_0000);
    run_txn(1'b0, 3'b011, 64'h4002, 64'd0,                64'd0,                   0, 1'b1, 64'd0,                   8'h00, 64'd0);
    run_txn(1'b0, 3'b010, 64'h5004, 64'd0,                64'h8765_4321_0000_0000, 5, 1'b0, 64'hFFFF_FFFF_8765_4321, 8'hF0, 64'd0);
    run_txn(1'b1, 3'b000, 64'h6005, 64'h0000_0000_0000_00AB, 64'd0,                0, 1'b0, 64'd0,                   8'h20, 64'h0000_AB00_0000_0000);
    run_txn(1'b1, 3'b011, 64'h7000, 64'h0123_4567_89AB_CDEF, 64'd0,                0, 1'b0, 64'd0,                   8'hFF, 64'h0123_4567_89AB_CDEF);
    run_txn(1'b0, 3'b110, 64'h8000, 64'd0,                64'h0000_0000_F000_0001, 0, 1'b0, 64'h0000_0000_F000_0001, 8'h0F, 64'd0);
    run_txn(1'b0, 3'b001, 64'h9002, 64'd0,                64'h0000_0000_8001_0000, 0, 1'b0, 64'hFFFF_FFFF_FFFF_8001, 8'h0C, 64'd0);
    run_txn(1'b1, 3'b001, 64'hA001, 64'h0000_0000_0000_5555, 64'd0,                0, 1'b1, 64'd0,                   8'h00, 64'd0);
    run_txn(1'b0, 3'b111, 64'hC000, 64'd0,                64'd0,                   0, 1'b1, 64'd0,                   8'h00, 64'd0);
    run_txn(1'b0, 3'b011, 64'hD008, 64'd0,                64'h1122_3344_5566_7788, 0, 1'b0, 64'h1122_3344_5566_7788, 8'hFF, 64'd0);

    // Reset while the load sits in WAIT; the late response must be dropped.
    resp_delay = 3;
    mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    mem_stall  = 0;
    req_q.push_back('{we: 1'b0, addr: 64'hE000, wdata: 64'd0, mask: 8'hFF});
    a0              = accepts;
    done_flag       = 1'b0;
    bus.core_valid  = 1'b1;
    bus.core_we     = 1'b0;
    bus.core_funct3 = 3'b011;
    bus.core_addr   = 64'hE000;
    bus.core_wdata  = 64'd0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (accepts == a0 + 1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) flag_fail("wait_entry_timeout");
    rst            = 1'b1;
    bus.core_valid = 1'b0;
    #1;
    chk("async_rst_rdata",     bus.core_rdata,              64'd0);
    chk("async_rst_done",      {63'd0, bus.core_done},      64'd0);
    chk("async_rst_req_valid", {63'd0, bus.dmem_req_valid}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_no_done",   {63'd0, done_flag},          64'd0);
    chk("post_rst_rdata",     bus.core_rdata,              64'd0);
    chk("post_rst_req_valid", {63'd0, bus.dmem_req_valid}, 64'd0);
    chk("post_rst_accepts",   64'(accepts),                64'(a0 + 1));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire
